// File: rtl/hex_print_sched.sv
// ---------------------------------------------------------------------------
// hex_print_sched
//
// Shares the single write port of the 64-cell OLED character buffer between
// NREQ requesters. Each requester asks to print a 32-bit value as upper-case
// hex ASCII starting at a chosen cell. Requests are granted round-robin and
// serialised into one buffer write per cycle, most significant digit first.
//
// Ports:
//   clk      - system clock
//   rst      - synchronous reset, active-high
//   req      - per-channel request level, held until ack
//   val      - channel i value at [32i+31:32i]
//   base     - channel i start cell at [ADDR_W*i+ADDR_W-1:ADDR_W*i]
//   stall    - hold-off; no grant in IDLE, no write in WRITE while high
//   ack      - one-cycle one-hot grant pulse (first WRITE cycle)
//   busy     - high while a request is being written
//   we       - buffer write enable
//   wr_addr  - buffer write address (wraps modulo 2^ADDR_W)
//   wr_data  - ASCII character to write
//
// Every output is a flop. The decision taken at a clock edge (from the inputs
// sampled at that edge) appears on the outputs in the following cycle, so
// there is no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module hex_print_sched #(
    parameter int NREQ   = 4,
    parameter int DIGITS = 8,
    parameter int ADDR_W = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*32-1:0]       val,
    input  logic [NREQ*ADDR_W-1:0]   base,
    input  logic                     stall,
    output logic [NREQ-1:0]          ack,
    output logic                     busy,
    output logic                     we,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [7:0]               wr_data
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int GNT_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [GNT_W-1:0]    last_grant_q, last_grant_d;
    logic [31:0]         val_q, val_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [NREQ-1:0]     ack_q, ack_d;
    logic                busy_q, busy_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]          wr_data_q, wr_data_d;

    logic                found;
    logic [GNT_W-1:0]    cand;
    logic [GNT_W-1:0]    winner;
    logic [31:0]         win_val;
    logic [ADDR_W-1:0]   win_base;

    // ASCII of nibble 'pos' of v: 0-9 -> '0'-'9', 10-15 -> 'A'-'F'.
    function automatic logic [7:0] hex_ascii(input logic [31:0] v,
                                             input int unsigned pos);
        logic [3:0] nib;
        nib = 4'(v >> (4 * pos));
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

    // Round-robin search: start just after the last winner and take the
    // first requesting channel. Also selects that channel's value and base
    // so the first digit can be presented right after the grant edge.
    always_comb begin
        found    = 1'b0;
        cand     = '0;
        winner   = '0;
        win_val  = '0;
        win_base = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = GNT_W'((int'(last_grant_q) + i) % NREQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (winner == GNT_W'(i)) begin
                win_val  = val[32*i +: 32];
                win_base = base[ADDR_W*i +: ADDR_W];
            end
        end
    end

    // Next-state and next-output computation. cnt always names the digit
    // currently on wr_addr/wr_data; we_q says whether it is being written
    // this cycle. A stall presents the next digit with we low, so the
    // address already points at the pending cell while the write is held.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        val_d        = val_q;
        base_d       = base_q;
        ack_d        = '0;
        we_d         = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;

        case (state_q)
            IDLE: begin
                if (found && !stall) begin
                    state_d      = WRITE;
                    cnt_d        = '0;
                    last_grant_d = winner;
                    val_d        = win_val;
                    base_d       = win_base;
                    ack_d        = NREQ'(1) << winner;
                    we_d         = 1'b1;
                    wr_addr_d    = win_base;
                    wr_data_d    = hex_ascii(win_val, DIGITS - 1);
                end
            end
            WRITE: begin
                if (we_q) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d     = cnt_q + CNT_W'(1);
                        we_d      = !stall;
                        wr_addr_d = base_q + ADDR_W'(cnt_q) + ADDR_W'(1);
                        wr_data_d = hex_ascii(val_q, DIGITS - 2 - int'(cnt_q));
                    end
                end else begin
                    // Stalled digit: resume writing it once stall drops.
                    we_d = !stall;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == WRITE);
    end

    // All state and outputs in one register bank. Reset aborts any print in
    // progress and makes channel 0 the highest priority again.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= GNT_W'(NREQ - 1);
            val_q        <= '0;
            base_q       <= '0;
            ack_q        <= '0;
            busy_q       <= 1'b0;
            we_q         <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            val_q        <= val_d;
            base_q       <= base_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
            we_q         <= we_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign ack     = ack_q;
    assign busy    = busy_q;
    assign we      = we_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule
